// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small valid/ready FIFO; bit timing comes from
// baud_tick_in, everything is clocked by clk_in.
//
// state  | meaning
// IDLE   | line high, waiting for a tick while a word is queued
// START  | start bit (0) on the line
// DATA   | data bit idx on the line, LSB first
// PARITY | parity bit on the line
// STOP   | stop bit stop_cnt on the line
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        baud_tick_in,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  output logic                        tx_out,
  output logic                        busy_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);
  localparam logic          PAR_INV  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_n;
  logic                  push, pop, fifo_ne;
  logic [DATA_WIDTH-1:0] head_word;

  logic [DATA_WIDTH-1:0] word_q, word_n;
  logic [IW-1:0]         idx, idx_n;
  logic                  stop_cnt, stop_cnt_n, stop_last;
  logic                  par, par_n, tx_n, busy_n;

  assign ready_out      = (count != DEPTH_C);
  assign fifo_ne        = (count != '0);
  assign push           = valid_in && ready_out;
  assign head_word      = mem[rd_ptr];
  assign fifo_count_out = count;
  assign stop_last      = (STOP_BITS == 1) ? 1'b1 : stop_cnt;

  always_comb begin
    count_n = count;
    if (push && !pop)      count_n = count + 1'b1;
    else if (pop && !push) count_n = count - 1'b1;
  end

  // Storage has no reset; pointers and count define which entries are live.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    if (baud_tick_in) begin
      case (state)
        IDLE: if (fifo_ne) begin
          pop     = 1'b1;
          state_n = START;
        end
        START:  state_n = DATA;
        DATA:   if (idx == LAST_IDX) state_n = (PARITY_EN != 0) ? PARITY : STOP;
        PARITY: state_n = STOP;
        STOP: if (stop_last) begin
          if (fifo_ne) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    tx_n       = tx_out;
    word_n     = word_q;
    idx_n      = idx;
    stop_cnt_n = stop_cnt;
    par_n      = par;
    if (baud_tick_in) begin
      case (state)
        START: begin
          tx_n  = word_q[0];
          idx_n = '0;
        end
        DATA: begin
          if (idx != LAST_IDX) begin
            idx_n = idx + 1'b1;
            tx_n  = word_q[idx + 1'b1];
          end else begin
            tx_n       = (PARITY_EN != 0) ? par : 1'b1;
            stop_cnt_n = 1'b0;
          end
        end
        PARITY: begin
          tx_n       = 1'b1;
          stop_cnt_n = 1'b0;
        end
        STOP: begin
          tx_n = 1'b1;
          if (!stop_last) stop_cnt_n = 1'b1;
        end
        default: tx_n = 1'b1;
      endcase
      // A pop always starts a new frame: latch the word and its parity.
      if (pop) begin
        word_n = head_word;
        par_n  = (^head_word) ^ PAR_INV;
        tx_n   = 1'b0;
      end
    end
    busy_n = (state_n != IDLE) || (count_n != '0);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tx_out   <= 1'b1;
      busy_out <= 1'b0;
      word_q   <= '0;
      idx      <= '0;
      stop_cnt <= 1'b0;
      par      <= 1'b0;
    end else begin
      tx_out   <= tx_n;
      busy_out <= busy_n;
      word_q   <= word_n;
      idx      <= idx_n;
      stop_cnt <= stop_cnt_n;
      par      <= par_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations share one stimulus stream and
// are checked every cycle against a frame-list model, plus literal frame checks.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;

  logic       tx_o    [4];
  logic       busy_o  [4];
  logic       ready_o [4];
  logic [2:0] cnt_o   [4];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo u0 (
    .clk_in(clk), .rst_in(rst), .baud_tick_in(tick), .data_in(data), .valid_in(valid),
    .ready_out(ready_o[0]), .tx_out(tx_o[0]), .busy_out(busy_o[0]), .fifo_count_out(cnt_o[0])
  );
  uart_tx_fifo #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk_in(clk), .rst_in(rst), .baud_tick_in(tick), .data_in(data), .valid_in(valid),
    .ready_out(ready_o[1]), .tx_out(tx_o[1]), .busy_out(busy_o[1]), .fifo_count_out(cnt_o[1])
  );
  uart_tx_fifo #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk_in(clk), .rst_in(rst), .baud_tick_in(tick), .data_in(data), .valid_in(valid),
    .ready_out(ready_o[2]), .tx_out(tx_o[2]), .busy_out(busy_o[2]), .fifo_count_out(cnt_o[2])
  );
  uart_tx_fifo #(.STOP_BITS(2)) u3 (
    .clk_in(clk), .rst_in(rst), .baud_tick_in(tick), .data_in(data), .valid_in(valid),
    .ready_out(ready_o[3]), .tx_out(tx_o[3]), .busy_out(busy_o[3]), .fifo_count_out(cnt_o[3])
  );

  function automatic int cfg_pe(input int k);
    return (k == 1 || k == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_po(input int k);
    return (k == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_sb(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  // Whole frame as a bit list, bit 0 first on the line.
  function automatic logic [15:0] build_frame(input logic [7:0] w, input int k, output int len);
    logic [15:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = w;
    len    = 9;
    if (cfg_pe(k) != 0) begin
      f[9] = (^w) ^ (cfg_po(k) != 0);
      len  = len + 1;
    end
    len = len + cfg_sb(k);
    return f;
  endfunction

  task automatic chk(input string name, input int k, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  logic [7:0]  mq [4][4];
  int          mhead [4];
  int          mcnt [4];
  int          flen [4];
  logic [15:0] fbits [4];
  logic        mact [4];
  logic        mtx [4];
  bit          m_acc;
  int          m_len;
  logic [7:0]  m_w;

  initial forever begin
    @(posedge clk or posedge rst);
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        mhead[k] = 0; mcnt[k] = 0; flen[k] = 0;
        fbits[k] = '1; mact[k] = 1'b0; mtx[k] = 1'b1;
      end else begin
        m_acc = valid && (mcnt[k] < 4);
        if (tick) begin
          if (flen[k] > 0) begin
            mtx[k]   = fbits[k][0];
            fbits[k] = fbits[k] >> 1;
            flen[k]--;
          end else if (mcnt[k] > 0) begin
            m_w      = mq[k][mhead[k]];
            mhead[k] = (mhead[k] + 1) % 4;
            mcnt[k]--;
            fbits[k] = build_frame(m_w, k, m_len);
            mtx[k]   = fbits[k][0];
            fbits[k] = fbits[k] >> 1;
            flen[k]  = m_len - 1;
            mact[k]  = 1'b1;
          end else begin
            mtx[k]  = 1'b1;
            mact[k] = 1'b0;
          end
        end
        if (m_acc) begin
          mq[k][(mhead[k] + mcnt[k]) % 4] = data;
          mcnt[k]++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        chk("tx", k, int'(tx_o[k]), int'(mtx[k]));
        chk("busy", k, int'(busy_o[k]), int'(mact[k] || mcnt[k] != 0));
        chk("count", k, int'(cnt_o[k]), mcnt[k]);
        chk("ready", k, int'(ready_o[k]), int'(mcnt[k] < 4));
      end
    end
  end

  logic [63:0] cap [4];
  logic [63:0] bcap [4];
  int ci = 0;

  task automatic clr_cap();
    ci = 0;
    for (int k = 0; k < 4; k++) begin
      cap[k]  = '0;
      bcap[k] = '0;
    end
  endtask

  task automatic push(input logic [7:0] w);
    data  = w;
    valid = 1'b1;
    @(posedge clk); #2;
    valid = 1'b0;
  endtask

  // One tick every gap cycles; line state after each tick is logged.
  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(posedge clk); #2;
      tick = 1'b0;
      for (int k = 0; k < 4; k++) begin
        cap[k][ci]  = tx_o[k];
        bcap[k][ci] = busy_o[k];
      end
      ci++;
      repeat (gap - 1) begin
        @(posedge clk); #2;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b1;
    chk("rst_tx", 0, int'(tx_o[0]), 1);
    chk("rst_ready", 0, int'(ready_o[0]), 1);
    chk("rst_busy", 0, int'(busy_o[0]), 0);
    chk("rst_count", 0, int'(cnt_o[0]), 0);
    rst = 1'b0;
    @(posedge clk); #2;

    clr_cap();
    push(8'h55);
    ticks(14, 8);
    chk("f55_line", 0, int'(cap[0][13:0]), 'h3EAA);
    chk("f55_busy_stop", 0, int'(bcap[0][9]), 1);
    chk("f55_busy_after", 0, int'(bcap[0][10]), 0);
    chk("f55_even_par", 1, int'(cap[1][9]), 0);

    clr_cap();
    push(8'h07);
    ticks(14, 8);
    chk("f07_line_even", 1, int'(cap[1][13:0]), 'h3E0E);
    chk("f07_par_even", 1, int'(cap[1][9]), 1);
    chk("f07_par_odd", 2, int'(cap[2][9]), 0);
    chk("f07_busy_t11", 1, int'(bcap[1][10]), 1);
    chk("f07_busy_t12", 1, int'(bcap[1][11]), 0);

    clr_cap();
    push(8'hFF);
    ticks(14, 8);
    chk("fff_line_2stop", 3, int'(cap[3][13:0]), 'h3FFE);
    chk("fff_busy_stop2", 3, int'(bcap[3][10]), 1);
    chk("fff_busy_idle", 3, int'(bcap[3][11]), 0);

    valid = 1'b1;
    data  = 8'hA1; @(posedge clk); #2;
    data  = 8'hB2; @(posedge clk); #2;
    data  = 8'hC3; @(posedge clk); #2;
    data  = 8'hD4; @(posedge clk); #2;
    data  = 8'hEE;
    chk("full_count", 0, int'(cnt_o[0]), 4);
    chk("full_ready", 0, int'(ready_o[0]), 0);
    @(posedge clk); #2;
    valid = 1'b0;
    chk("full_reject", 0, int'(cnt_o[0]), 4);
    clr_cap();
    ticks(50, 4);
    chk("b2b_frame1", 0, int'(cap[0][9:0]), 'h342);
    chk("b2b_start2", 0, int'(cap[0][10]), 0);
    chk("b2b_start3", 0, int'(cap[0][20]), 0);
    chk("b2b_start4", 0, int'(cap[0][30]), 0);
    chk("b2b_idle", 0, int'(cap[0][40]), 1);
    chk("b2b_done", 0, int'(bcap[0][40]), 0);
    chk("b2b_start2_s2", 3, int'(cap[3][11]), 0);

    push(8'h11);
    push(8'h22);
    push(8'h33);
    clr_cap();
    ticks(4, 8);
    chk("pre_rst_count", 0, int'(cnt_o[0]), 2);
    chk("pre_rst_tx", 0, int'(tx_o[0]), 0);
    #1 rst = 1'b1;
    #1;
    chk("async_tx", 0, int'(tx_o[0]), 1);
    chk("async_count", 0, int'(cnt_o[0]), 0);
    chk("async_busy", 0, int'(busy_o[0]), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    clr_cap();
    ticks(20, 4);
    chk("post_rst_line", 0, int'(cap[0][19:0]), 'hFFFFF);
    chk("post_rst_busy", 0, int'(bcap[0][19:0]), 0);

    push(8'h3C);
    push(8'h5A);
    chk("hold_pre_count", 0, int'(cnt_o[0]), 2);
    tick  = 1'b1;
    valid = 1'b1;
    data  = 8'h81;
    @(posedge clk); #2;
    valid = 1'b0;
    for (int k = 0; k < 4; k++) chk("pushpop_count", k, int'(cnt_o[k]), 2);
    repeat (60) begin
      @(posedge clk); #2;
    end
    tick = 1'b0;
    for (int k = 0; k < 4; k++) chk("hold_drained", k, int'(busy_o[k]), 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
